// File: rtl/key_debounce.sv
// key_debounce: multi-channel synchroniser and debounce filter for mechanical keys.
// Each channel has a 2-flop synchroniser feeding a 2-state filter FSM; key_level
// only follows the synchronised input after it has persisted long enough.
// Optional long-press detection is compiled in with `define KEY_DEBOUNCE_LONG_PRESS_EN.
module key_debounce #(
  parameter int                CH_NUM        = 4,
  parameter int                STABLE_CYCLES = 20000,
  parameter logic [CH_NUM-1:0] IDLE_LEVEL    = {CH_NUM{1'b1}},
  parameter int                LONG_CYCLES   = 1000000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [CH_NUM-1:0] key_raw,
  output logic [CH_NUM-1:0] key_level,
  output logic [CH_NUM-1:0] key_busy,
  output logic [CH_NUM-1:0] key_long
);

  localparam int CW = $clog2(STABLE_CYCLES + 1);
  // The synchronised value has already been held for one cycle when the FSM
  // first notices it, so the edge on which the count would reach
  // STABLE_CYCLES is the commit edge; in FILTER that is when cnt holds
  // STABLE_CYCLES-1.
  localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYCLES - 1);

  typedef enum logic {
    ST_STABLE = 1'b0,
    ST_FILTER = 1'b1
  } state_t;

  // Catch nonsensical configurations at elaboration time
  if (CH_NUM < 1 || CH_NUM > 32 || STABLE_CYCLES < 1 || LONG_CYCLES < 1) begin : g_badConfig
    $error("key_debounce: illegal parameter combination");
  end

  logic [CH_NUM-1:0] r_sync1;
  logic [CH_NUM-1:0] r_sync2;
  logic [CH_NUM-1:0] r_level;
  logic [CH_NUM-1:0] w_levelNext;

  // Two-flop synchroniser; keeps running regardless of en
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= IDLE_LEVEL;
      r_sync2 <= IDLE_LEVEL;
    end else begin
      r_sync1 <= key_raw;
      r_sync2 <= r_sync1;
    end
  end

  // Debounced level register, updated only on a per-channel commit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_level <= IDLE_LEVEL;
    end else begin
      r_level <= w_levelNext;
    end
  end

  assign key_level = r_level;

  for (genvar g = 0; g < CH_NUM; g++) begin : g_ch
    state_t        r_state;
    state_t        w_stateNext;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cntNext;
    logic          w_commit;

    // Filter state and persistence counter for this channel
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_state <= ST_STABLE;
        r_cnt   <= '0;
      end else begin
        r_state <= w_stateNext;
        r_cnt   <= w_cntNext;
      end
    end

    // Next-state logic: start filtering on a difference, abort on a glitch,
    // commit once the new value has persisted; en low parks the channel
    always_comb begin
      w_stateNext = r_state;
      w_cntNext   = r_cnt;
      w_commit    = 1'b0;
      if (!en) begin
        w_stateNext = ST_STABLE;
        w_cntNext   = '0;
      end else begin
        case (r_state)
          ST_STABLE: begin
            if (r_sync2[g] != r_level[g]) begin
              if (STABLE_CYCLES == 1) begin
                w_commit = 1'b1;
              end else begin
                w_stateNext = ST_FILTER;
                w_cntNext   = CW'(1);
              end
            end
          end
          ST_FILTER: begin
            if (r_sync2[g] == r_level[g]) begin
              w_stateNext = ST_STABLE;
              w_cntNext   = '0;
            end else if (r_cnt == CNT_LAST) begin
              w_commit    = 1'b1;
              w_stateNext = ST_STABLE;
              w_cntNext   = '0;
            end else begin
              w_cntNext = r_cnt + CW'(1);
            end
          end
          default: begin
            w_stateNext = ST_STABLE;
            w_cntNext   = '0;
          end
        endcase
      end
    end

    assign w_levelNext[g] = w_commit ? r_sync2[g] : r_level[g];
    assign key_busy[g]    = (r_state == ST_FILTER);
  end

`ifdef KEY_DEBOUNCE_LONG_PRESS_EN
  localparam int LW = $clog2(LONG_CYCLES + 1);
  localparam logic [LW-1:0] LONG_MAX  = LW'(LONG_CYCLES);
  localparam logic [LW-1:0] LONG_PREV = LW'(LONG_CYCLES - 1);

  for (genvar g = 0; g < CH_NUM; g++) begin : g_long
    logic [LW-1:0] r_longCnt;
    logic          r_long;

    // Long-press timer: counts while pressed and enabled, freezes when en is
    // low, and clears on the same edge that returns key_level to idle
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_longCnt <= '0;
        r_long    <= 1'b0;
      end else if (w_levelNext[g] == IDLE_LEVEL[g]) begin
        r_longCnt <= '0;
        r_long    <= 1'b0;
      end else if (en && (r_level[g] != IDLE_LEVEL[g]) && (r_longCnt != LONG_MAX)) begin
        r_longCnt <= r_longCnt + LW'(1);
        if (r_longCnt == LONG_PREV) begin
          r_long <= 1'b1;
        end
      end
    end

    assign key_long[g] = r_long;
  end
`else
  assign key_long = '0;
`endif

endmodule
